// File: rtl/mult_err_pkg.sv
// Shared types and helpers for the multiplier error monitor: FSM states, default widths
// and a wide signed-magnitude helper used by the S1 stage.
package mult_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_PROD_W  = 16;
    localparam int DEF_SAMPLES = 65536;
    localparam int DEF_CNT_W   = 17;
    localparam int DEF_ACC_W   = 40;

    // Wide enough that |a-b| of two 31-bit signed products never wraps.
    localparam int ABS_W = 33;

    function automatic logic [ABS_W-1:0] abs_x(input logic signed [ABS_W-1:0] v);
        return v[ABS_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/err_abs_stage.sv
// S1 of the error monitor: registers |approx-exact|, |exact| and a mismatch flag, 1-cycle latency.
// No backpressure; i_flush discards whatever would be captured on this edge.
module err_abs_stage
    import mult_err_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_vld,
    input  logic signed [PROD_W-1:0] i_exact,
    input  logic signed [PROD_W-1:0] i_approx,
    output logic                     o_vld,
    output logic [PROD_W:0]          o_ed,
    output logic [PROD_W:0]          o_abs_exact,
    output logic                     o_nz
);

    if (PROD_W > ABS_W - 2) begin : g_width_chk
        $error("err_abs_stage: PROD_W exceeds the abs helper width");
    end

    logic signed [ABS_W-1:0] exact_x;
    logic signed [ABS_W-1:0] approx_x;
    logic [ABS_W-1:0]        ed_full;
    logic [ABS_W-1:0]        abs_exact_full;
    logic                    vld_d, vld_q;
    logic                    nz_d, nz_q;
    logic [PROD_W:0]         ed_d, ed_q;
    logic [PROD_W:0]         abs_exact_d, abs_exact_q;
    logic                    unused_hi;

    always_comb begin
        exact_x        = {{(ABS_W-PROD_W){i_exact[PROD_W-1]}}, i_exact};
        approx_x       = {{(ABS_W-PROD_W){i_approx[PROD_W-1]}}, i_approx};
        ed_full        = abs_x(approx_x - exact_x);
        abs_exact_full = abs_x(exact_x);

        vld_d       = i_vld & ~i_flush;
        ed_d        = ed_q;
        abs_exact_d = abs_exact_q;
        nz_d        = nz_q;
        if (vld_d) begin
            // PROD_W+1 bits hold both 2^(PROD_W-1) and the largest difference magnitude.
            ed_d        = ed_full[PROD_W:0];
            abs_exact_d = abs_exact_full[PROD_W:0];
            nz_d        = (i_approx != i_exact);
        end
    end

    // Upper bits of the wide helper results are always zero here.
    assign unused_hi = ^{ed_full[ABS_W-1:PROD_W+1], abs_exact_full[ABS_W-1:PROD_W+1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q       <= 1'b0;
            ed_q        <= '0;
            abs_exact_q <= '0;
            nz_q        <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            ed_q        <= ed_d;
            abs_exact_q <= abs_exact_d;
            nz_q        <= nz_d;
        end
    end

    assign o_vld       = vld_q;
    assign o_ed        = ed_q;
    assign o_abs_exact = abs_exact_q;
    assign o_nz        = nz_q;

endmodule

// File: rtl/mult_error_monitor.sv
// Error-statistics collector for an exact/approx multiplier pair; stats lag the accept by 2 edges.
// Ready only in RUN, deasserted after the SAMPLES-th accept; i_start restarts and flushes at any time.
module mult_error_monitor
    import mult_err_pkg::*;
#(
    parameter int PROD_W  = DEF_PROD_W,
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [PROD_W-1:0] i_exact,
    input  logic signed [PROD_W-1:0] i_approx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_count,
    output logic [CNT_W-1:0]         o_err_cnt,
    output logic [ACC_W-1:0]         o_sum_ed,
    output logic [PROD_W:0]          o_max_ed,
    output logic [PROD_W:0]          o_max_exact,
    output logic                     o_ovf
);

    localparam int               ED_W     = PROD_W + 1;
    localparam int               SUM_W    = ((ACC_W > ED_W) ? ACC_W : ED_W) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);

    if (SAMPLES < 1) begin : g_samples_chk
        $error("mult_error_monitor: SAMPLES must be at least 1");
    end
    if (CNT_W < $clog2(SAMPLES + 1)) begin : g_cnt_chk
        $error("mult_error_monitor: CNT_W cannot hold SAMPLES");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             accept;
    logic             last_accept;

    logic             s1_vld;
    logic             s1_nz;
    logic [ED_W-1:0]  s1_ed;
    logic [ED_W-1:0]  s1_abs_exact;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [SUM_W-1:0] sum_ext;
    logic [ED_W-1:0]  max_ed_q, max_ed_d;
    logic [ED_W-1:0]  max_exact_q, max_exact_d;
    logic             ovf_q, ovf_d;

    // A start in the same cycle as a valid pair wins; the pair is dropped.
    assign o_ready     = (state_q == ST_RUN);
    assign accept      = i_valid & o_ready & ~i_start;
    assign last_accept = accept & (acc_cnt_q == LAST_IDX);

    err_abs_stage #(
        .PROD_W (PROD_W)
    ) u_s1 (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_start),
        .i_vld       (accept),
        .i_exact     (i_exact),
        .i_approx    (i_approx),
        .o_vld       (s1_vld),
        .o_ed        (s1_ed),
        .o_abs_exact (s1_abs_exact),
        .o_nz        (s1_nz)
    );

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        if (i_start) begin
            state_d   = ST_RUN;
            acc_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                        if (last_accept) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                // S1 holds the final pair during DRAIN; S2 absorbs it on this edge.
                ST_DRAIN: state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        count_d     = count_q;
        err_cnt_d   = err_cnt_q;
        sum_d       = sum_q;
        max_ed_d    = max_ed_q;
        max_exact_d = max_exact_q;
        ovf_d       = ovf_q;
        sum_ext     = SUM_W'(sum_q) + SUM_W'(s1_ed);

        if (i_start) begin
            count_d     = '0;
            err_cnt_d   = '0;
            sum_d       = '0;
            max_ed_d    = '0;
            max_exact_d = '0;
            ovf_d       = 1'b0;
        end else if (s1_vld) begin
            count_d   = count_q + 1'b1;
            err_cnt_d = err_cnt_q + CNT_W'(s1_nz);
            if (|sum_ext[SUM_W-1:ACC_W]) begin
                sum_d = '1;
                ovf_d = 1'b1;
            end else begin
                sum_d = sum_ext[ACC_W-1:0];
            end
            if (s1_ed > max_ed_q) begin
                max_ed_d = s1_ed;
            end
            if (s1_abs_exact > max_exact_q) begin
                max_exact_d = s1_abs_exact;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            acc_cnt_q   <= '0;
            count_q     <= '0;
            err_cnt_q   <= '0;
            sum_q       <= '0;
            max_ed_q    <= '0;
            max_exact_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            count_q     <= count_d;
            err_cnt_q   <= err_cnt_d;
            sum_q       <= sum_d;
            max_ed_q    <= max_ed_d;
            max_exact_q <= max_exact_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);
    assign o_count     = count_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_sum_ed    = sum_q;
    assign o_max_ed    = max_ed_q;
    assign o_max_exact = max_exact_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Bench for mult_error_monitor: three instances (4-sample/16-bit sum, 10-sample, full sweep)
// checked against constants and a queue-based statistics model.
module tb_mult_error_monitor;

    localparam int PW = 16;
    localparam int CW = 17;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    logic                 s_start, s_valid, s_ready, s_busy, s_done, s_ovf;
    logic signed [PW-1:0] s_exact, s_approx;
    logic [CW-1:0]        s_count, s_err;
    logic [15:0]          s_sum;
    logic [PW:0]          s_max_ed, s_max_ex;

    logic                 m_start, m_valid, m_ready, m_busy, m_done, m_ovf;
    logic signed [PW-1:0] m_exact, m_approx;
    logic [CW-1:0]        m_count, m_err;
    logic [39:0]          m_sum;
    logic [PW:0]          m_max_ed, m_max_ex;

    logic                 f_start, f_valid, f_ready, f_busy, f_done, f_ovf;
    logic signed [PW-1:0] f_exact, f_approx;
    logic [CW-1:0]        f_count, f_err;
    logic [39:0]          f_sum;
    logic [PW:0]          f_max_ed, f_max_ex;

    mult_error_monitor #(.PROD_W(PW), .SAMPLES(4), .CNT_W(CW), .ACC_W(16)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_valid(s_valid), .o_ready(s_ready),
        .i_exact(s_exact), .i_approx(s_approx), .o_busy(s_busy), .o_done(s_done),
        .o_count(s_count), .o_err_cnt(s_err), .o_sum_ed(s_sum), .o_max_ed(s_max_ed),
        .o_max_exact(s_max_ex), .o_ovf(s_ovf)
    );

    mult_error_monitor #(.PROD_W(PW), .SAMPLES(10), .CNT_W(CW), .ACC_W(40)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(m_start), .i_valid(m_valid), .o_ready(m_ready),
        .i_exact(m_exact), .i_approx(m_approx), .o_busy(m_busy), .o_done(m_done),
        .o_count(m_count), .o_err_cnt(m_err), .o_sum_ed(m_sum), .o_max_ed(m_max_ed),
        .o_max_exact(m_max_ex), .o_ovf(m_ovf)
    );

    mult_error_monitor #(.PROD_W(PW), .SAMPLES(65536), .CNT_W(CW), .ACC_W(40)) u_full (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(f_start), .i_valid(f_valid), .o_ready(f_ready),
        .i_exact(f_exact), .i_approx(f_approx), .o_busy(f_busy), .o_done(f_done),
        .o_count(f_count), .o_err_cnt(f_err), .o_sum_ed(f_sum), .o_max_ed(f_max_ed),
        .o_max_exact(f_max_ex), .o_ovf(f_ovf)
    );

    // Reference model: the list of pairs the run should have accumulated.
    int     q_ed[$];
    int     q_ex[$];
    int     q_nz[$];
    int     exp_cnt, exp_err, exp_max_ed, exp_max_ex;
    longint exp_sum;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rnd_prod();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_clear();
        q_ed.delete();
        q_ex.delete();
        q_nz.delete();
    endtask

    task automatic model_push(input int e, input int a);
        q_ed.push_back(iabs(a - e));
        q_ex.push_back(iabs(e));
        q_nz.push_back((a != e) ? 1 : 0);
    endtask

    function automatic void model_eval();
        exp_cnt    = q_ed.size();
        exp_err    = 0;
        exp_sum    = 0;
        exp_max_ed = 0;
        exp_max_ex = 0;
        foreach (q_ed[i]) begin
            exp_err += q_nz[i];
            exp_sum += longint'(q_ed[i]);
            if (q_ed[i] > exp_max_ed) exp_max_ed = q_ed[i];
            if (q_ex[i] > exp_max_ex) exp_max_ex = q_ex[i];
        end
    endfunction

    task automatic s_start_run();
        @(posedge clk); #1;
        s_start = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        s_start = 1'b0;
    endtask

    task automatic s_send(input int e, input int a);
        s_exact  = PW'(e);
        s_approx = PW'(a);
        s_valid  = 1'b1;
        @(posedge clk); #1;
        s_valid  = 1'b0;
    endtask

    task automatic m_start_run();
        @(posedge clk); #1;
        m_start = 1'b1;
        m_valid = 1'b0;
        @(posedge clk); #1;
        m_start = 1'b0;
    endtask

    task automatic m_send(input int e, input int a);
        m_exact  = PW'(e);
        m_approx = PW'(a);
        m_valid  = 1'b1;
        model_push(e, a);
        @(posedge clk); #1;
        m_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({s_ready, s_busy, s_done, s_ovf, s_count, s_err, s_sum, s_max_ed, s_max_ex} !== '0) begin
            n_fail++;
            $display("FAIL reset_small: ready=%b busy=%b done=%b count=%0d sum=%0d, all must be 0",
                     s_ready, s_busy, s_done, s_count, s_sum);
        end
        n_tests++;
        if ({m_ready, m_busy, m_done, m_ovf, m_count, m_err, m_sum, m_max_ed, m_max_ex} !== '0) begin
            n_fail++;
            $display("FAIL reset_main: ready=%b busy=%b done=%b count=%0d sum=%0d, all must be 0",
                     m_ready, m_busy, m_done, m_count, m_sum);
        end
        n_tests++;
        if ({f_ready, f_busy, f_done, f_ovf, f_count, f_err, f_sum, f_max_ed, f_max_ex} !== '0) begin
            n_fail++;
            $display("FAIL reset_full: ready=%b busy=%b done=%b count=%0d, all must be 0",
                     f_ready, f_busy, f_done, f_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ignore();
        s_exact  = PW'(123);
        s_approx = PW'(-7);
        s_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        n_tests++;
        if (s_ready !== 1'b0 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: ready=%b busy=%b, required 0 0", s_ready, s_busy);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (s_count !== '0 || s_sum !== '0) begin
            n_fail++;
            $display("FAIL idle_ignore: count=%0d sum=%0d, required 0 0", s_count, s_sum);
        end
    endtask

    task automatic test_basic();
        s_start_run();
        n_tests++;
        if (s_ready !== 1'b1 || s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_run: ready=%b busy=%b, required 1 1", s_ready, s_busy);
        end
        s_send(16384, 16000);
        s_send(-100, -90);
        s_send(50, 60);
        s_send(7, 7);
        // Last accept edge just passed: ready drops, three pairs visible, not done yet.
        n_tests++;
        if (s_ready !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_drain: ready=%b done=%b busy=%b, required 0 0 1", s_ready, s_done, s_busy);
        end
        n_tests++;
        if (s_count !== 17'd3) begin
            n_fail++;
            $display("FAIL basic_latency: count=%0d, required 3", s_count);
        end
        s_valid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (s_done !== 1'b1 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b, required 1 0", s_done, s_busy);
        end
        n_tests++;
        if (s_count !== 17'd4 || s_err !== 17'd3) begin
            n_fail++;
            $display("FAIL basic_counts: count=%0d err=%0d, required 4 3", s_count, s_err);
        end
        n_tests++;
        if (s_sum !== 16'd404 || s_max_ed !== 17'd384 || s_max_ex !== 17'd16384) begin
            n_fail++;
            $display("FAIL basic_stats: sum=%0d max_ed=%0d max_exact=%0d, required 404 384 16384",
                     s_sum, s_max_ed, s_max_ex);
        end
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        n_tests++;
        if (s_count !== 17'd4 || s_done !== 1'b1 || s_sum !== 16'd404) begin
            n_fail++;
            $display("FAIL basic_hold: count=%0d done=%b sum=%0d, required 4 1 404", s_count, s_done, s_sum);
        end
    endtask

    task automatic test_no_wrap();
        s_start_run();
        s_send(-32768, 0);
        s_send(0, 0);
        s_send(0, 0);
        s_send(0, 0);
        @(posedge clk); #1;
        n_tests++;
        if (s_max_ed !== 17'd32768 || s_max_ex !== 17'd32768) begin
            n_fail++;
            $display("FAIL nowrap_max: max_ed=%0d max_exact=%0d, required 32768 32768", s_max_ed, s_max_ex);
        end
        n_tests++;
        if (s_sum !== 16'd32768 || s_err !== 17'd1 || s_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL nowrap_sum: sum=%0d err=%0d ovf=%b, required 32768 1 0", s_sum, s_err, s_ovf);
        end
    endtask

    task automatic test_saturate();
        s_start_run();
        n_tests++;
        if (s_sum !== '0 || s_done !== 1'b0 || s_max_ed !== '0) begin
            n_fail++;
            $display("FAIL sat_clear: sum=%0d done=%b max_ed=%0d, required 0 0 0", s_sum, s_done, s_max_ed);
        end
        for (int i = 0; i < 4; i++) s_send(0, 30000);
        @(posedge clk); #1;
        n_tests++;
        if (s_sum !== 16'hFFFF || s_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_value: sum=%0d ovf=%b, required 65535 1", s_sum, s_ovf);
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (s_ovf !== 1'b1 || s_count !== 17'd4 || s_max_ed !== 17'd30000) begin
            n_fail++;
            $display("FAIL sat_sticky: ovf=%b count=%0d max_ed=%0d, required 1 4 30000", s_ovf, s_count, s_max_ed);
        end
        s_start_run();
        n_tests++;
        if (s_ovf !== 1'b0 || s_sum !== '0) begin
            n_fail++;
            $display("FAIL sat_restart: ovf=%b sum=%0d, required 0 0", s_ovf, s_sum);
        end
    endtask

    task automatic test_random_valid();
        int  n_acc;
        int  e, a;
        logic v;
        n_acc = 0;
        model_clear();
        m_start_run();
        for (int cyc = 0; cyc < 45; cyc++) begin
            n_tests++;
            if (m_ready !== (n_acc < 10)) begin
                n_fail++;
                $display("FAIL rnd_ready cycle %0d: ready=%b, required %b", cyc, m_ready, (n_acc < 10));
            end
            e = rnd_prod();
            a = ($urandom_range(0, 3) == 0) ? e : rnd_prod();
            v = (cyc >= 25) || ($urandom_range(0, 3) != 0);
            m_exact  = PW'(e);
            m_approx = PW'(a);
            m_valid  = v;
            if (v && n_acc < 10) begin
                model_push(e, a);
                n_acc++;
            end
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
        model_eval();
        n_tests++;
        if (m_count !== CW'(exp_cnt) || m_err !== CW'(exp_err)) begin
            n_fail++;
            $display("FAIL rnd_counts: count=%0d err=%0d, required %0d %0d", m_count, m_err, exp_cnt, exp_err);
        end
        n_tests++;
        if (m_sum !== 40'(exp_sum)) begin
            n_fail++;
            $display("FAIL rnd_sum: sum=%0d, required %0d", m_sum, exp_sum);
        end
        n_tests++;
        if (m_max_ed !== 17'(exp_max_ed) || m_max_ex !== 17'(exp_max_ex)) begin
            n_fail++;
            $display("FAIL rnd_max: max_ed=%0d max_exact=%0d, required %0d %0d",
                     m_max_ed, m_max_ex, exp_max_ed, exp_max_ex);
        end
        n_tests++;
        if (m_done !== 1'b1 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_done: done=%b ovf=%b, required 1 0", m_done, m_ovf);
        end
    endtask

    task automatic test_restart();
        model_clear();
        m_start_run();
        for (int i = 0; i < 5; i++) m_send(rnd_prod(), rnd_prod());
        model_clear();
        // Restart with a valid pair on the same cycle: that pair must be dropped.
        m_exact  = PW'(1000);
        m_approx = PW'(-1000);
        m_valid  = 1'b1;
        m_start  = 1'b1;
        @(posedge clk); #1;
        m_start = 1'b0;
        m_valid = 1'b0;
        n_tests++;
        if (m_count !== '0 || m_sum !== '0 || m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: count=%0d sum=%0d ready=%b, required 0 0 1", m_count, m_sum, m_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (m_count !== '0) begin
            n_fail++;
            $display("FAIL restart_flush: count=%0d, required 0", m_count);
        end
        for (int i = 0; i < 10; i++) m_send(rnd_prod(), ($urandom_range(0, 2) == 0) ? 5 : rnd_prod());
        @(posedge clk); #1;
        model_eval();
        n_tests++;
        if (m_count !== CW'(exp_cnt) || m_err !== CW'(exp_err) || m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_counts: count=%0d err=%0d done=%b, required %0d %0d 1",
                     m_count, m_err, m_done, exp_cnt, exp_err);
        end
        n_tests++;
        if (m_sum !== 40'(exp_sum) || m_max_ed !== 17'(exp_max_ed) || m_max_ex !== 17'(exp_max_ex)) begin
            n_fail++;
            $display("FAIL restart_stats: sum=%0d max_ed=%0d max_exact=%0d, required %0d %0d %0d",
                     m_sum, m_max_ed, m_max_ex, exp_sum, exp_max_ed, exp_max_ex);
        end
    endtask

    task automatic test_full_sweep();
        int n_sent;
        int max_ex;
        n_sent = 0;
        max_ex = 0;
        @(posedge clk); #1;
        f_start = 1'b1;
        @(posedge clk); #1;
        f_start = 1'b0;
        for (int a = -128; a < 128; a++) begin
            for (int b = -128; b < 128; b++) begin
                f_exact  = PW'(a * b);
                f_approx = PW'(a * b);
                f_valid  = 1'b1;
                if (iabs(a * b) > max_ex) max_ex = iabs(a * b);
                n_sent++;
                @(posedge clk); #1;
            end
        end
        f_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (f_count !== CW'(n_sent) || f_err !== '0 || f_done !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_counts: count=%0d err=%0d done=%b, required %0d 0 1", f_count, f_err, f_done, n_sent);
        end
        n_tests++;
        if (f_sum !== '0 || f_max_ed !== '0 || f_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_err: sum=%0d max_ed=%0d ovf=%b, required 0 0 0", f_sum, f_max_ed, f_ovf);
        end
        n_tests++;
        if (f_max_ex !== 17'(max_ex)) begin
            n_fail++;
            $display("FAIL sweep_max_exact: max_exact=%0d, required %0d", f_max_ex, max_ex);
        end
    endtask

    task automatic test_reset_mid();
        m_start_run();
        m_send(300, 310);
        m_send(-5, 5);
        m_send(40, 40);
        n_tests++;
        if (m_count !== 17'd2 || m_sum !== 40'd20) begin
            n_fail++;
            $display("FAIL midrst_pre: count=%0d sum=%0d, required 2 20", m_count, m_sum);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({m_ready, m_busy, m_done, m_ovf, m_count, m_err, m_sum, m_max_ed, m_max_ex} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: ready=%b busy=%b count=%0d sum=%0d max_ed=%0d, all must be 0",
                     m_ready, m_busy, m_count, m_sum, m_max_ed);
        end
        #2;
        rst_n = 1'b1;
        m_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_valid = 1'b0;
        n_tests++;
        if (m_count !== '0 || m_busy !== 1'b0 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: count=%0d busy=%b ready=%b, required 0 0 0", m_count, m_busy, m_ready);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        s_start  = 1'b0; s_valid = 1'b0; s_exact = '0; s_approx = '0;
        m_start  = 1'b0; m_valid = 1'b0; m_exact = '0; m_approx = '0;
        f_start  = 1'b0; f_valid = 1'b0; f_exact = '0; f_approx = '0;

        test_reset();
        test_idle_ignore();
        test_basic();
        test_no_wrap();
        test_saturate();
        test_random_valid();
        test_restart();
        test_full_sweep();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
